// File: rtl/booth_mac_acc.sv
// booth_mac_acc: accumulates ACC_LEN signed 64-bit products from the Booth
// multiplier's four-phase req/ack output.
// The finished, sign-extended sum is offered on a valid/ready port.
// req_in is synchronised into clk before use.
module booth_mac_acc #(
    parameter int ACC_LEN     = 8,
    parameter int ACC_W       = 72,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      prod_in,
    input  logic             req_in,
    output logic             ack_out,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [8:0] LEN_C       = 9'(ACC_LEN);
    localparam logic [1:0] FLUSH_LEN_C = 2'(SYNC_STAGES);

    state_t                 state_r, state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    logic [8:0]             cnt_r, cnt_nxt_s;
    logic [1:0]             flush_cnt_r, flush_cnt_nxt_s;
    logic [ACC_W-1:0]       acc_r, acc_nxt_s;
    logic                   ovf_r, ovf_nxt_s;
    logic                   ack_r, ack_nxt_s;
    logic                   valid_r, valid_nxt_s;
    logic [ACC_W-1:0]       prod_ext_s;
    logic [ACC_W-1:0]       sum_s;
    logic                   ovf_add_s;

    // Synchroniser chain for the asynchronous request line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s = sync_r[SYNC_STAGES-1];

    // Sign-extended add with two's-complement overflow detection.
    always_comb begin
        prod_ext_s = ACC_W'($signed(prod_in));
        sum_s      = acc_r + prod_ext_s;
        ovf_add_s  = (acc_r[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                     (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
    end

    // Next-state and next-datapath logic for the handshake/accumulate FSM.
    // FLUSH first lets the synchroniser refill from live req_in.
    // After that, a request held high across reset is seen and waited out.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        flush_cnt_nxt_s = flush_cnt_r;
        acc_nxt_s       = acc_r;
        ovf_nxt_s       = ovf_r;
        ack_nxt_s       = ack_r;
        valid_nxt_s     = valid_r;
        case (state_r)
            ST_FLUSH: begin
                ack_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
                if (flush_cnt_r != FLUSH_LEN_C) begin
                    flush_cnt_nxt_s = flush_cnt_r + 2'd1;
                end else if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_IDLE: begin
                if (req_s) begin
                    acc_nxt_s   = sum_s;
                    cnt_nxt_s   = cnt_r + 9'd1;
                    ovf_nxt_s   = ovf_r | ovf_add_s;
                    ack_nxt_s   = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    ack_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!req_s) begin
                    ack_nxt_s = 1'b0;
                    if (cnt_r == LEN_C) begin
                        valid_nxt_s = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    ack_nxt_s   = 1'b1;
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                ack_nxt_s = 1'b0;
                if (valid_r && acc_ready) begin
                    acc_nxt_s   = '0;
                    cnt_nxt_s   = 9'd0;
                    ovf_nxt_s   = 1'b0;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                ack_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
                state_nxt_s = ST_FLUSH;
            end
        endcase
    end

    // State and datapath registers; reset wins over any same-cycle event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_FLUSH;
            cnt_r       <= 9'd0;
            flush_cnt_r <= 2'd0;
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            ack_r       <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
            acc_r       <= acc_nxt_s;
            ovf_r       <= ovf_nxt_s;
            ack_r       <= ack_nxt_s;
            valid_r     <= valid_nxt_s;
        end
    end

    assign ack_out   = ack_r;
    assign acc_out   = acc_r;
    assign acc_valid = valid_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc.
// Four instances with different parameters: dut 0 ACC_LEN=2, dut 1
// ACC_W=64/ACC_LEN=2, dut 2 ACC_LEN=1, dut 3 ACC_LEN=8.
// Expected results are queued when stimulus is issued.
// A negedge monitor pops and compares them at every result handoff.
module tb_booth_mac_acc;

    logic        clk;
    logic [3:0]  req;
    logic [3:0]  ready;
    logic [3:0]  rst;
    logic [63:0] prod [4];

    logic [71:0] acc_a, acc_c, acc_d;
    logic [63:0] acc_b;
    logic ack_a, ack_b, ack_c, ack_d;
    logic val_a, val_b, val_c, val_d;
    logic ovf_a, ovf_b, ovf_c, ovf_d;
    wire  [3:0] ack_v = {ack_d, ack_c, ack_b, ack_a};
    wire  [3:0] val_v = {val_d, val_c, val_b, val_a};
    wire  [3:0] ovf_v = {ovf_d, ovf_c, ovf_b, ovf_a};

    typedef struct packed {
        logic [1:0]   dut;
        logic [127:0] acc;
        logic         ovf;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   passes = 0;
    int   ack_cnt_d = 0;
    logic ack_d_prev = 1'b0;

    booth_mac_acc #(.ACC_LEN(2), .ACC_W(72), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(rst[0]), .prod_in(prod[0]), .req_in(req[0]), .ack_out(ack_a),
        .acc_out(acc_a), .acc_valid(val_a), .acc_ready(ready[0]), .ovf(ovf_a));
    booth_mac_acc #(.ACC_LEN(2), .ACC_W(64), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(rst[1]), .prod_in(prod[1]), .req_in(req[1]), .ack_out(ack_b),
        .acc_out(acc_b), .acc_valid(val_b), .acc_ready(ready[1]), .ovf(ovf_b));
    booth_mac_acc #(.ACC_LEN(1), .ACC_W(72), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .reset(rst[2]), .prod_in(prod[2]), .req_in(req[2]), .ack_out(ack_c),
        .acc_out(acc_c), .acc_valid(val_c), .acc_ready(ready[2]), .ovf(ovf_c));
    booth_mac_acc #(.ACC_LEN(8), .ACC_W(72), .SYNC_STAGES(2)) dut_d (
        .clk(clk), .reset(rst[3]), .prod_in(prod[3]), .req_in(req[3]), .ack_out(ack_d),
        .acc_out(acc_d), .acc_valid(val_d), .acc_ready(ready[3]), .ovf(ovf_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] acc_of(input int d);
        case (d)
            0:       return 128'($signed(acc_a));
            1:       return 128'($signed(acc_b));
            2:       return 128'($signed(acc_c));
            3:       return 128'($signed(acc_d));
            default: return 128'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act === want) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic push(input int d, input logic [127:0] acc, input logic ovf);
        exp_t e;
        e.dut = 2'(d);
        e.acc = acc;
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // Bounded wait for ack of dut d to reach level v.
    task automatic wait_ack(input int d, input logic v);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (ack_v[d] == v) break;
        end
        chk($sformatf("wait_ack%0d_dut%0d", v, d), 128'(ack_v[d]), 128'(v));
    endtask

    // One full four-phase handshake carrying product p.
    task automatic hs(input int d, input logic [63:0] p);
        prod[d] = p;
        req[d]  = 1'b1;
        wait_ack(d, 1'b1);
        req[d] = 1'b0;
        wait_ack(d, 1'b0);
        prod[d] = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    // Scoreboard monitor: compares each result as it is handed off.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            if (val_v[d] && ready[d] && !rst[d]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected_result_dut%0d", d), acc_of(d), 128'h0);
                    checks++;
                    $display("FAIL sb_empty: dut%0d presented a result, none expected", d);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_dut", 128'(d), 128'(e.dut));
                    chk($sformatf("sb_acc_dut%0d", d), acc_of(d), e.acc);
                    chk($sformatf("sb_ovf_dut%0d", d), 128'(ovf_v[d]), 128'(e.ovf));
                end
            end
        end
        if (ack_d && !ack_d_prev) ack_cnt_d++;
        ack_d_prev = ack_d;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [30:0]  ma, mb;
        logic signed [63:0]  p64;
        logic signed [127:0] ref_sum;
        logic [63:0]         prods [8];
        int                  stay;

        req   = 4'h0;
        ready = 4'hF;
        rst   = 4'hF;
        for (int d = 0; d < 4; d++) prod[d] = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_acc_dut%0d", d), acc_of(d), 128'h0);
            chk($sformatf("rst_ack_dut%0d", d), 128'(ack_v[d]), 128'h0);
            chk($sformatf("rst_valid_dut%0d", d), 128'(val_v[d]), 128'h0);
            chk($sformatf("rst_ovf_dut%0d", d), 128'(ovf_v[d]), 128'h0);
        end
        rst = 4'h0;
        repeat (6) @(posedge clk);

        // Latency on dut 2: req_in rises at edge k, ack from edge k+3.
        push(2, 128'd11, 1'b0);
        @(posedge clk);
        #1;
        prod[2] = 64'd11;
        req[2]  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("lat_ack_early", 128'(ack_c), 128'h0);
        @(posedge clk);
        #1;
        chk("lat_ack_rise", 128'(ack_c), 128'h1);
        repeat (6) @(posedge clk);
        #1;
        req[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("lat_ack_late", 128'(ack_c), 128'h1);
        @(posedge clk);
        #1;
        chk("lat_ack_fall", 128'(ack_c), 128'h0);
        repeat (4) @(posedge clk);

        // Backpressure on dut 2: result 7 held while a new request waits.
        #1;
        ready[2] = 1'b0;
        push(2, 128'd7, 1'b0);
        hs(2, 64'd7);
        prod[2] = 64'd20;
        req[2]  = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_ack_low", 128'(ack_c), 128'h0);
            chk("bp_acc_hold", acc_of(2), 128'd7);
            chk("bp_valid", 128'(val_c), 128'h1);
        end
        push(2, 128'd20, 1'b0);
        ready[2] = 1'b1;
        wait_ack(2, 1'b1);
        req[2] = 1'b0;
        wait_ack(2, 1'b0);
        repeat (4) @(posedge clk);

        // Reset mid-HOLD on dut 2: pending request is not re-accepted.
        #1;
        prod[2] = 64'd5;
        req[2]  = 1'b1;
        wait_ack(2, 1'b1);
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        chk("rsthold_ack_drop", 128'(ack_c), 128'h0);
        chk("rsthold_acc_clr", acc_of(2), 128'h0);
        stay = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ack_c) stay++;
        end
        chk("rsthold_no_reaccept", 128'(stay), 128'h0);
        req[2] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        push(2, 128'd9, 1'b0);
        hs(2, 64'd9);
        repeat (4) @(posedge clk);

        // Basic accumulate on dut 0: 3 + (-5) = -2.
        #1;
        push(0, {{56{1'b1}}, 72'hFF_FFFF_FFFF_FFFF_FFFE}, 1'b0);
        hs(0, 64'd3);
        hs(0, 64'hFFFF_FFFF_FFFF_FFFB);
        repeat (4) @(posedge clk);

        // Overflow on dut 1 (64-bit): 2^62 + 2^62 wraps, then ovf clears.
        #1;
        push(1, {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000}, 1'b1);
        hs(1, 64'h4000_0000_0000_0000);
        hs(1, 64'h4000_0000_0000_0000);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_cleared", 128'(ovf_b), 128'h0);
        push(1, 128'd3, 1'b0);
        hs(1, 64'd1);
        hs(1, 64'd2);
        repeat (4) @(posedge clk);

        // Full run on dut 3: eight 31x31-bit signed products.
        #1;
        ref_sum = 128'sd0;
        for (int i = 0; i < 8; i++) begin
            ma       = 31'($urandom);
            mb       = 31'($urandom);
            p64      = ma * mb;
            prods[i] = p64;
            ref_sum  = ref_sum + 128'(p64);
        end
        push(3, ref_sum, 1'b0);
        for (int i = 0; i < 8; i++) hs(3, prods[i]);
        repeat (10) @(posedge clk);
        #1;
        chk("ack_pulses_full", 128'(ack_cnt_d), 128'd8);
        chk("queue_empty", 128'(exp_q.size()), 128'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
